// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared types and constants for the ALU issue front-end.
//   state_t     : issue FSM states
//   OP_*        : ALU opcode encodings
//   WIDTH       : default operand/result width (must match the ALU)
package alu_issue_pkg;
    localparam int WIDTH = 16;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;
    typedef enum logic [1:0] {IDLE, CFG, CAPT, RESP} state_t;
endpackage

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: valid/ready front-end that programs the ALU opcode, issues
// operands, captures the result and returns it with a divide-by-zero flag.
// Ports:
//   CLK, RESET              clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake; req_op, req_a, req_b payload
//   resp_valid/resp_ready   response handshake; resp_c, resp_op, resp_dz payload
//   alu_a, alu_b            registered operands to the ALU
//   alu_c                   combinational ALU result
//   config_data, config_en  ALU opcode register write port
// Optional: ALU_OPCODE_CACHE_EN skips the config cycle when the requested
// opcode is already programmed into the ALU.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = alu_issue_pkg::WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_c,
    output logic [1:0]       resp_op,
    output logic             resp_dz,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_c,
    output logic [1:0]       config_data,
    output logic             config_en
);
    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d, rop_q, rop_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic             dz_q, dz_d, hit, dz_now;

`ifdef ALU_OPCODE_CACHE_EN
    logic       cache_vld_q;
    logic [1:0] cache_op_q;
    // The ALU opcode register is not reset, so the cache must forget on reset.
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            cache_vld_q <= 1'b0;
            cache_op_q  <= '0;
        end else if (state_q == CFG) begin
            cache_vld_q <= 1'b1;
            cache_op_q  <= op_q;
        end
    assign hit = cache_vld_q && (req_op == cache_op_q);
`else
    assign hit = 1'b0;
`endif

    // Outputs decode straight from registered state so reset clears them at once.
    assign req_ready   = state_q == IDLE;
    assign config_en   = state_q == CFG;
    assign config_data = config_en ? op_q : 2'd0;
    assign resp_valid  = state_q == RESP;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign resp_c      = c_q;
    assign resp_op     = rop_q;
    assign resp_dz     = dz_q;
    assign dz_now      = (op_q == OP_DIV) && (b_q == '0);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        rop_d   = rop_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (req_valid) begin
                op_d    = req_op;
                a_d     = req_a;
                b_d     = req_b;
                state_d = hit ? CAPT : CFG;
            end
            CFG:  state_d = CAPT;
            CAPT: begin
                // The ALU leaves divide-by-zero undefined; return all ones instead.
                c_d     = dz_now ? '1 : alu_c;
                rop_d   = op_q;
                dz_d    = dz_now;
                state_d = RESP;
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            rop_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            rop_q   <= rop_d;
            dz_q    <= dz_d;
        end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized self-checking bench for alu_issue_ctrl with a
// behavioural ALU attached; expected results and latencies come from a
// transaction-level reference model.
module tb_alu_issue_ctrl;
    logic        CLK = 1'b0, RESET = 1'b1;
    logic        req_valid = 1'b0, resp_ready = 1'b0;
    logic [1:0]  req_op = '0;
    logic [15:0] req_a = '0, req_b = '0;
    logic        req_ready, resp_valid, resp_dz, config_en;
    logic [15:0] resp_c, alu_a, alu_b, alu_c;
    logic [1:0]  resp_op, config_data;
    logic [1:0]  alu_op_q = '0;
    int          checks = 0, errors = 0;
    bit          m_cache_vld = 0;
    logic [1:0]  m_cache_op = '0;

    alu_issue_ctrl #(.WIDTH(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_c(resp_c),
        .resp_op(resp_op), .resp_dz(resp_dz),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .config_data(config_data), .config_en(config_en)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] arith(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = a * b;
        case (op)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: return p[15:0];
            default: return (b == 0) ? 16'h5A5A : a / b;
        endcase
    endfunction

    // Behavioural ALU: opcode register (never reset) plus combinational result.
    always @(posedge CLK) if (config_en) alu_op_q <= config_data;
    assign alu_c = arith(alu_op_q, alu_a, alu_b);

    function automatic logic [15:0] ref_c(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        return (op == 2'd3 && b == 0) ? 16'hFFFF : arith(op, a, b);
    endfunction

    // Entered and left just after a falling edge.
    task automatic do_txn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [15:0] ec;
        logic        edz;
        int          lat, cfg_seen, w;
        ec  = ref_c(op, a, b);
        edz = (op == 2'd3 && b == 0);
        lat = 3;
`ifdef ALU_OPCODE_CACHE_EN
        if (m_cache_vld && m_cache_op == op) lat = 2;
        m_cache_vld = 1;
        m_cache_op  = op;
`endif
        req_valid = 1; req_op = op; req_a = a; req_b = b;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL accept_ready got=%b exp=1", req_ready); end
        @(posedge CLK);
        #1 req_valid = 0; req_op = 2'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
        cfg_seen = 0;
        for (int n = 1; n <= lat; n++) begin
            @(negedge CLK);
            checks++;
            if (config_en === 1'b1) begin
                cfg_seen++;
                if (config_data !== op) begin errors++; $display("FAIL config_data got=%0d exp=%0d", config_data, op); end
            end else if (config_data !== 2'd0) begin errors++; $display("FAIL config_data_idle got=%0d exp=0", config_data); end
            if (n == 1) begin
                checks++;
                if (alu_a !== a || alu_b !== b) begin errors++; $display("FAIL operands got=%h/%h exp=%h/%h", alu_a, alu_b, a, b); end
            end
            if (n < lat) begin
                checks++;
                if (resp_valid !== 1'b0) begin errors++; $display("FAIL early_resp n=%0d got=%b exp=0", n, resp_valid); end
            end
        end
        checks++;
        if (cfg_seen != (lat == 3 ? 1 : 0)) begin errors++; $display("FAIL cfg_pulses got=%0d exp=%0d", cfg_seen, lat == 3 ? 1 : 0); end
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++; $display("FAIL latency resp_valid=%b at %0d cycles exp=1", resp_valid, lat);
            w = 0;
            while (resp_valid !== 1'b1 && w < 10) begin @(negedge CLK); w++; end
        end
        checks++;
        if (resp_c !== ec || resp_op !== op || resp_dz !== edz || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL resp op=%0d a=%h b=%h got c=%h op=%0d dz=%b rdy=%b exp c=%h op=%0d dz=%b rdy=0",
                     op, a, b, resp_c, resp_op, resp_dz, req_ready, ec, op, edz);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            checks++;
            if (resp_valid !== 1'b1 || resp_c !== ec || resp_dz !== edz || resp_op !== op || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure h=%0d got v=%b c=%h dz=%b rdy=%b exp v=1 c=%h dz=%b rdy=0",
                         h, resp_valid, resp_c, resp_dz, req_ready, ec, edz);
            end
        end
        resp_ready = 1;
        @(posedge CLK);
        #1 resp_ready = 0;
        @(negedge CLK);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL release got v=%b rdy=%b exp v=0 rdy=1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (req_ready !== 1 || resp_valid !== 0 || config_en !== 0 || resp_dz !== 0 ||
            resp_c !== 0 || resp_op !== 0 || alu_a !== 0 || alu_b !== 0 || config_data !== 0) begin
            errors++;
            $display("FAIL reset_state rdy=%b v=%b cen=%b dz=%b c=%h op=%0d a=%h b=%h cd=%0d exp rdy=1 rest=0",
                     req_ready, resp_valid, config_en, resp_dz, resp_c, resp_op, alu_a, alu_b, config_data);
        end
        @(negedge CLK);
        @(negedge CLK);
        RESET = 0;
        @(negedge CLK);
        checks++;
        if (req_ready !== 1 || resp_valid !== 0 || config_en !== 0) begin
            errors++; $display("FAIL idle rdy=%b v=%b cen=%b exp 1/0/0", req_ready, resp_valid, config_en);
        end
    endtask

    task automatic test_add;
        do_txn(2'd0, 16'd3, 16'd4, 0);
    endtask

    task automatic test_div;
        do_txn(2'd3, 16'd100, 16'd0, 1);
        do_txn(2'd3, 16'd100, 16'd7, 0);
    endtask

    task automatic test_backpressure;
        do_txn(2'd2, 16'h0100, 16'h0100, 5);
    endtask

    task automatic test_reset_mid;
        req_valid = 1; req_op = 2'd2; req_a = 16'd9; req_b = 16'd9;
        @(posedge CLK);
        #1 req_valid = 0;
        #2 RESET = 1;
        #1;
        checks++;
        if (config_en !== 0 || resp_valid !== 0 || req_ready !== 1 || resp_c !== 0 || alu_a !== 0 || config_data !== 0) begin
            errors++;
            $display("FAIL reset_mid cen=%b v=%b rdy=%b c=%h a=%h cd=%0d exp cen=0 v=0 rdy=1 c=0 a=0 cd=0",
                     config_en, resp_valid, req_ready, resp_c, alu_a, config_data);
        end
        @(negedge CLK);
        RESET = 0;
        m_cache_vld = 0;
        do_txn(2'd1, 16'd5, 16'd9, 0);
    endtask

    task automatic test_back_to_back;
        do_txn(2'd0, 16'd1000, 16'd2000, 0);
        do_txn(2'd0, 16'hFFFF, 16'd2, 0);
        do_txn(2'd1, 16'd7, 16'd3, 0);
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [15:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = 16'($urandom);
            b  = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
            do_txn(op, a, b, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_backpressure;
        test_div;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
